can_tx_frame_scheduler: RTL

Transmit-side controller for the CAN data-frame datapath. It arbitrates among NUM_MB transmit mailboxes by CAN priority (lowest identifier wins) and latches the winner's identifier and DLC. It then sequences the field blocks (SOF, identifier, control, data, CRC, ACK, EOF) one at a time through per-field enables and their completion flags, and reports done, arbitration-loss retry, and ACK-error abort per mailbox.

---
 rtl/can_tx_frame_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/can_tx_frame_scheduler.sv
// can_tx_frame_scheduler
//   Transmit-side controller for the CAN data-frame datapath. Picks the
//   highest-priority (lowest identifier) eligible mailbox and latches its
//   identifier and DLC. It then steps the field blocks SOF..EOF one at a time
//   and reports frame completion or ACK-error abort for each mailbox.
//
// Ports
//   clock, reset_n          system clock, asynchronous active-low reset
//   enable                  controller enable; low returns to IDLE on next edge
//   bus_idle, sample_point  bus idle indication, bit-time sample strobe
//   tx_req, mb_id, mb_dlc   per-mailbox request level, identifiers, DLCs
//   *_complete              field-block completion pulses
//   arb_lost, ack_error     arbitration loss during ID, recessive ACK slot
//   *_en                    field-block enables (at most one high)
//   tx_identifier, tx_dlc   latched winner identifier / DLC
//   active_mb, busy         mailbox being sent, not-IDLE indication
//   tx_done, tx_abort       one-cycle one-hot per-mailbox result pulses
module can_tx_frame_scheduler #(
    parameter int unsigned NUM_MB    = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   bus_idle,
    input  logic                   sample_point,
    input  logic [NUM_MB-1:0]      tx_req,
    input  logic [11*NUM_MB-1:0]   mb_id,
    input  logic [4*NUM_MB-1:0]    mb_dlc,
    input  logic                   sof_complete,
    input  logic                   id_complete,
    input  logic                   ctrl_complete,
    input  logic                   data_complete,
    input  logic                   crc_complete,
    input  logic                   ack_complete,
    input  logic                   eof_complete,
    input  logic                   arb_lost,
    input  logic                   ack_error,
    output logic                   sof_en,
    output logic                   id_en,
    output logic                   ctrl_en,
    output logic                   data_en,
    output logic                   crc_en,
    output logic                   ack_en,
    output logic                   eof_en,
    output logic [10:0]            tx_identifier,
    output logic [3:0]             tx_dlc,
    output logic [2:0]             active_mb,
    output logic                   busy,
    output logic [NUM_MB-1:0]      tx_done,
    output logic [NUM_MB-1:0]      tx_abort
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_SOF, S_ID, S_CTRL, S_DATA, S_CRC, S_ACK, S_EOF, S_IFS
    } state_t;

    state_t              state, state_nx;
    logic [NUM_MB-1:0]   abort_mask;
    logic [NUM_MB-1:0]   eligible;
    logic [NUM_MB-1:0]   active_onehot;
    logic [3:0]          retry_cnt;
    logic [3:0]          retry_inc;
    logic [2:0]          last_mb;
    logic [1:0]          ifs_cnt;
    logic                abort_hit;
    logic                win_found;
    logic [2:0]          win_idx;
    logic [10:0]         win_id;
    logic [3:0]          win_dlc;

    // Identifiers with the seven MSBs all recessive are not transmittable.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            eligible[i] = tx_req[i] && !abort_mask[i] && (mb_id[11*i+4 +: 7] != 7'h7F);
        end
    end

    // Ascending scan with strict compare: equal identifiers go to the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_id    = 11'h7FF;
        win_dlc   = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (eligible[i] && (!win_found || (mb_id[11*i +: 11] < win_id))) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_id    = mb_id[11*i +: 11];
                win_dlc   = mb_dlc[4*i +: 4];
            end
        end
    end

    always_comb begin
        active_onehot = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (3'(i) == active_mb) active_onehot[i] = 1'b1;
        end
    end

    assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    assign abort_hit = (state == S_ACK) && ack_error && (retry_inc == 4'(MAX_RETRY));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus_idle && win_found) state_nx = S_ARB;
            S_ARB:  state_nx = S_SOF;
            S_SOF:  if (sof_complete) state_nx = S_ID;
            S_ID: begin
                if (arb_lost)         state_nx = S_IDLE;
                else if (id_complete) state_nx = S_CTRL;
            end
            S_CTRL: if (ctrl_complete) state_nx = (tx_dlc != 4'd0) ? S_DATA : S_CRC;
            S_DATA: if (data_complete) state_nx = S_CRC;
            S_CRC:  if (crc_complete)  state_nx = S_ACK;
            S_ACK: begin
                if (ack_error)         state_nx = S_IFS;
                else if (ack_complete) state_nx = S_EOF;
            end
            S_EOF:  if (eof_complete) state_nx = S_IFS;
            S_IFS:  if (sample_point && (ifs_cnt == 2'd2)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (!enable) state_nx = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_identifier <= 11'h7FF;
            tx_dlc        <= '0;
            active_mb     <= '0;
            last_mb       <= '0;
            retry_cnt     <= '0;
            abort_mask    <= '0;
            ifs_cnt       <= '0;
            tx_done       <= '0;
            tx_abort      <= '0;
        end else if (!enable) begin
            tx_identifier <= 11'h7FF;
            tx_dlc        <= '0;
            active_mb     <= '0;
            last_mb       <= '0;
            retry_cnt     <= '0;
            abort_mask    <= '0;
            ifs_cnt       <= '0;
            tx_done       <= '0;
            tx_abort      <= '0;
        end else begin
            tx_done  <= '0;
            tx_abort <= '0;
            // A dropped request releases the mask so a later request is eligible.
            abort_mask <= (abort_mask | (abort_hit ? active_onehot : '0)) & tx_req;

            if (state == S_IFS) begin
                if (sample_point) ifs_cnt <= ifs_cnt + 2'd1;
            end else begin
                ifs_cnt <= '0;
            end

            case (state)
                S_ARB: begin
                    tx_identifier <= win_id;
                    tx_dlc        <= win_dlc;
                    active_mb     <= win_idx;
                    last_mb       <= win_idx;
                    if (win_idx != last_mb) retry_cnt <= '0;
                end
                S_ACK: begin
                    if (ack_error) begin
                        if (abort_hit) begin
                            tx_abort  <= active_onehot;
                            retry_cnt <= '0;
                        end else begin
                            retry_cnt <= retry_inc;
                        end
                    end
                end
                S_EOF: begin
                    if (eof_complete) begin
                        tx_done   <= active_onehot;
                        retry_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sof_en  = (state == S_SOF);
    assign id_en   = (state == S_ID);
    assign ctrl_en = (state == S_CTRL);
    assign data_en = (state == S_DATA);
    assign crc_en  = (state == S_CRC);
    assign ack_en  = (state == S_ACK);
    assign eof_en  = (state == S_EOF);
    assign busy    = (state != S_IDLE);

endmodule
